// File: rtl/dd_mcu_mem_glue.sv
// Memory and glue around the Double Dragon 6801 MCU: address decode, shared and
// internal RAM, port register file with port 6 interrupt control, NMI latch, read mux.
module dd_mcu_mem_glue #(
  parameter int SHW = 9,
  parameter int IRW = 8
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           cen,
  input  logic           vma,
  input  logic           rnw,
  input  logic [15:0]    addr,
  input  logic [7:0]     mcu_dout,
  output logic [7:0]     mcu_din,
  input  logic [7:0]     rom_data,
  output logic           rom_cs,
  input  logic           nmi_set,
  output logic           nmi,
  output logic           irqmain,
  input  logic           halted,
  input  logic [SHW-1:0] cpu_ab,
  input  logic           cpu_wrn,
  input  logic [7:0]     cpu_dout,
  input  logic           com_cs,
  output logic [7:0]     shared_dout
);

  logic       ram_cs;
  logic       shared_cs;
  logic       port_cs;
  logic       port_we;
  logic       p6_sel;
  logic [7:0] port_rd;
  logic [7:0] p6_reg;
  logic       nmi_reg;
  logic       nmi_set_d;
  logic       nmi_clr;

  logic [7:0] shared_mem [0:(1<<SHW)-1];
  logic [7:0] shared_q0_reg;
  logic [7:0] shared_q1_reg;
  logic [7:0] iram_mem [0:(1<<IRW)-1];
  logic [7:0] iram_q_reg;
  logic [7:0] port_file [0:31];

  always_comb begin
    rom_cs    = vma && (addr[15:14] == 2'b11);
    ram_cs    = vma && (addr >= 16'h0040) && (addr < 16'h0140);
    shared_cs = vma && (addr[15:12] == 4'h8);
    port_cs   = vma && (addr < 16'h0028);
  end

  assign p6_sel  = (addr[5:0] == 6'h17);
  assign port_we = port_cs && !rnw && cen;
  assign port_rd = p6_sel ? p6_reg : port_file[addr[4:0]];

  always_comb begin
    mcu_din = rom_data;
    if (ram_cs)
      mcu_din = iram_q_reg;
    else if (shared_cs)
      mcu_din = shared_q0_reg;
    else if (port_cs)
      mcu_din = port_rd;
  end

  always_ff @(posedge clk) begin
    if (port_we && !p6_sel)
      port_file[addr[4:0]] <= mcu_dout;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)
      p6_reg <= 8'h00;
    else if (port_we && p6_sel)
      p6_reg <= mcu_dout;
  end

  assign irqmain = p6_reg[1];
  assign nmi_clr = ~p6_reg[0];
  assign nmi     = nmi_reg;

  // Clear outranks a coincident rising edge; a held level cannot re-arm the latch.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      nmi_set_d <= 1'b0;
      nmi_reg   <= 1'b0;
    end else begin
      nmi_set_d <= nmi_set;
      if (nmi_clr)
        nmi_reg <= 1'b0;
      else if (nmi_set && !nmi_set_d)
        nmi_reg <= 1'b1;
    end
  end

  // CPU port is written first so an MCU write to the same address overrides it.
  always_ff @(posedge clk) begin
    shared_q0_reg <= shared_mem[addr[SHW-1:0]];
    shared_q1_reg <= shared_mem[cpu_ab];
    if (!cpu_wrn && com_cs && halted)
      shared_mem[cpu_ab] <= cpu_dout;
    if (!rnw && shared_cs)
      shared_mem[addr[SHW-1:0]] <= mcu_dout;
  end

  assign shared_dout = shared_q1_reg;

  always_ff @(posedge clk) begin
    iram_q_reg <= iram_mem[addr[IRW-1:0]];
    if (ram_cs && !rnw && cen)
      iram_mem[addr[IRW-1:0]] <= mcu_dout;
  end

endmodule

// File: tb/tb_dd_mcu_mem_glue.sv
// Directed bench for dd_mcu_mem_glue: inputs driven and outputs sampled on the falling edge.
module tb_dd_mcu_mem_glue;

  logic        clk = 1'b0;
  logic        rstb;
  logic        cen;
  logic        vma;
  logic        rnw;
  logic [15:0] addr;
  logic [7:0]  mcu_dout;
  logic [7:0]  mcu_din;
  logic [7:0]  rom_data;
  logic        rom_cs;
  logic        nmi_set;
  logic        nmi;
  logic        irqmain;
  logic        halted;
  logic [8:0]  cpu_ab;
  logic        cpu_wrn;
  logic [7:0]  cpu_dout;
  logic        com_cs;
  logic [7:0]  shared_dout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dd_mcu_mem_glue #(.SHW(9), .IRW(8)) dut (
    .clk(clk), .rstb(rstb), .cen(cen), .vma(vma), .rnw(rnw), .addr(addr),
    .mcu_dout(mcu_dout), .mcu_din(mcu_din), .rom_data(rom_data), .rom_cs(rom_cs),
    .nmi_set(nmi_set), .nmi(nmi), .irqmain(irqmain), .halted(halted),
    .cpu_ab(cpu_ab), .cpu_wrn(cpu_wrn), .cpu_dout(cpu_dout), .com_cs(com_cs),
    .shared_dout(shared_dout)
  );

  task automatic mcu_idle();
    vma = 1'b0; rnw = 1'b1; cen = 1'b0;
  endtask

  task automatic cpu_idle();
    cpu_wrn = 1'b1; com_cs = 1'b0; halted = 1'b0;
  endtask

  // Called at a falling edge; the write lands on the following rising edge.
  task automatic mcu_write(input logic [15:0] a, input logic [7:0] d, input logic c);
    vma = 1'b1; rnw = 1'b0; cen = c; addr = a; mcu_dout = d;
    @(negedge clk);
    mcu_idle();
  endtask

  task automatic mcu_read(input logic [15:0] a);
    vma = 1'b1; rnw = 1'b1; cen = 1'b1; addr = a;
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic [7:0] d, input logic h);
    cpu_ab = a; cpu_dout = d; cpu_wrn = 1'b0; com_cs = 1'b1; halted = h;
    @(negedge clk);
    cpu_idle();
  endtask

  task automatic cpu_read(input logic [8:0] a);
    cpu_ab = a; com_cs = 1'b1; cpu_wrn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstb = 1'b0; nmi_set = 1'b0; rom_data = 8'h5E; addr = 16'h0000; mcu_dout = 8'h00;
    cpu_ab = 9'h000; cpu_dout = 8'h00;
    mcu_idle(); cpu_idle();
    repeat (2) @(negedge clk);
    if (nmi !== 1'b0) begin $display("FAIL reset_nmi got %b exp 0", nmi); errors++; end
    checks++;
    if (irqmain !== 1'b0) begin $display("FAIL reset_irqmain got %b exp 0", irqmain); errors++; end
    checks++;
    rstb = 1'b1;
    @(negedge clk);
    mcu_read(16'h0017);
    if (mcu_din !== 8'h00) begin $display("FAIL reset_p6_read got %h exp 00", mcu_din); errors++; end
    checks++;
    $display("test_reset done");
  endtask

  task automatic test_port();
    mcu_write(16'h0017, 8'h03, 1'b1);
    if (irqmain !== 1'b1) begin $display("FAIL p6_irqmain got %b exp 1", irqmain); errors++; end
    checks++;
    mcu_read(16'h0017);
    if (mcu_din !== 8'h03) begin $display("FAIL p6_read got %h exp 03", mcu_din); errors++; end
    checks++;
    mcu_write(16'h0005, 8'h05, 1'b1);
    mcu_read(16'h0005);
    if (mcu_din !== 8'h05) begin $display("FAIL port5_read got %h exp 05", mcu_din); errors++; end
    checks++;
    mcu_read(16'h0017);
    if (mcu_din !== 8'h03) begin $display("FAIL p6_unchanged got %h exp 03", mcu_din); errors++; end
    checks++;
    mcu_write(16'h0009, 8'hEE, 1'b0);
    mcu_read(16'h0009);
    mcu_write(16'h0009, 8'h1D, 1'b1);
    mcu_read(16'h0009);
    if (mcu_din !== 8'h1D) begin $display("FAIL port9_read got %h exp 1d", mcu_din); errors++; end
    checks++;
    mcu_idle();
    $display("test_port done");
  endtask

  task automatic test_nmi();
    if (nmi !== 1'b0) begin $display("FAIL nmi_idle got %b exp 0", nmi); errors++; end
    checks++;
    nmi_set = 1'b1;
    @(negedge clk);
    if (nmi !== 1'b1) begin $display("FAIL nmi_edge got %b exp 1", nmi); errors++; end
    checks++;
    repeat (3) @(negedge clk);
    if (nmi !== 1'b1) begin $display("FAIL nmi_hold got %b exp 1", nmi); errors++; end
    checks++;
    mcu_write(16'h0017, 8'h00, 1'b1);
    @(negedge clk);
    if (nmi !== 1'b0) begin $display("FAIL nmi_clear got %b exp 0", nmi); errors++; end
    checks++;
    mcu_write(16'h0017, 8'h01, 1'b1);
    repeat (2) @(negedge clk);
    if (nmi !== 1'b0) begin $display("FAIL nmi_no_retrigger got %b exp 0", nmi); errors++; end
    checks++;
    nmi_set = 1'b0;
    mcu_write(16'h0017, 8'h00, 1'b1);
    repeat (2) @(negedge clk);
    nmi_set = 1'b1;
    mcu_write(16'h0017, 8'h01, 1'b1);
    repeat (2) @(negedge clk);
    if (nmi !== 1'b0) begin $display("FAIL nmi_clear_priority got %b exp 0", nmi); errors++; end
    checks++;
    nmi_set = 1'b0;
    @(negedge clk);
    nmi_set = 1'b1;
    @(negedge clk);
    if (nmi !== 1'b1) begin $display("FAIL nmi_rearm got %b exp 1", nmi); errors++; end
    checks++;
    nmi_set = 1'b0;
    $display("test_nmi done");
  endtask

  task automatic test_shared();
    mcu_write(16'h8010, 8'hA5, 1'b1);
    cpu_read(9'h010);
    if (shared_dout !== 8'hA5) begin $display("FAIL shr_cpu_read got %h exp a5", shared_dout); errors++; end
    checks++;
    vma = 1'b1; rnw = 1'b0; cen = 1'b0; addr = 16'h8010; mcu_dout = 8'h66;
    @(negedge clk);
    if (mcu_din !== 8'hA5) begin $display("FAIL shr_rbw got %h exp a5", mcu_din); errors++; end
    checks++;
    mcu_idle();
    mcu_read(16'h8010);
    if (mcu_din !== 8'h66) begin $display("FAIL shr_nocen_write got %h exp 66", mcu_din); errors++; end
    checks++;
    mcu_write(16'h8020, 8'h11, 1'b1);
    cpu_write(9'h020, 8'h3C, 1'b0);
    mcu_read(16'h8020);
    if (mcu_din !== 8'h11) begin $display("FAIL shr_cpu_not_halted got %h exp 11", mcu_din); errors++; end
    checks++;
    mcu_idle();
    cpu_write(9'h020, 8'h3C, 1'b1);
    mcu_read(16'h8020);
    if (mcu_din !== 8'h3C) begin $display("FAIL shr_cpu_halted got %h exp 3c", mcu_din); errors++; end
    checks++;
    vma = 1'b1; rnw = 1'b0; cen = 1'b1; addr = 16'h8030; mcu_dout = 8'h5A;
    cpu_ab = 9'h030; cpu_dout = 8'hC3; cpu_wrn = 1'b0; com_cs = 1'b1; halted = 1'b1;
    @(negedge clk);
    mcu_idle(); cpu_idle();
    mcu_read(16'h8030);
    if (mcu_din !== 8'h5A) begin $display("FAIL shr_collide_mcu got %h exp 5a", mcu_din); errors++; end
    checks++;
    cpu_read(9'h030);
    if (shared_dout !== 8'h5A) begin $display("FAIL shr_collide_cpu got %h exp 5a", shared_dout); errors++; end
    checks++;
    mcu_idle(); cpu_idle();
    $display("test_shared done");
  endtask

  task automatic test_iram_mux();
    mcu_write(16'h0050, 8'h77, 1'b1);
    mcu_read(16'h0050);
    if (mcu_din !== 8'h77) begin $display("FAIL iram_read got %h exp 77", mcu_din); errors++; end
    checks++;
    mcu_write(16'h0050, 8'h99, 1'b0);
    mcu_read(16'h0050);
    if (mcu_din !== 8'h77) begin $display("FAIL iram_nocen got %h exp 77", mcu_din); errors++; end
    checks++;
    mcu_write(16'h013F, 8'h4B, 1'b1);
    mcu_read(16'h013F);
    if (mcu_din !== 8'h4B) begin $display("FAIL iram_top got %h exp 4b", mcu_din); errors++; end
    checks++;
    rom_data = 8'h5E;
    mcu_read(16'h0150);
    if (mcu_din !== 8'h5E) begin $display("FAIL mux_0150 got %h exp 5e", mcu_din); errors++; end
    checks++;
    if (rom_cs !== 1'b0) begin $display("FAIL rom_cs_0150 got %b exp 0", rom_cs); errors++; end
    checks++;
    rom_data = 8'hB7;
    mcu_read(16'hC123);
    if (rom_cs !== 1'b1) begin $display("FAIL rom_cs_c123 got %b exp 1", rom_cs); errors++; end
    checks++;
    if (mcu_din !== 8'hB7) begin $display("FAIL mux_c123 got %h exp b7", mcu_din); errors++; end
    checks++;
    vma = 1'b0; addr = 16'hC123;
    #1;
    if (rom_cs !== 1'b0) begin $display("FAIL rom_cs_novma got %b exp 0", rom_cs); errors++; end
    checks++;
    addr = 16'h0050;
    #1;
    if (mcu_din !== 8'hB7) begin $display("FAIL mux_novma got %h exp b7", mcu_din); errors++; end
    checks++;
    @(negedge clk);
    mcu_idle();
    $display("test_iram_mux done");
  endtask

  task automatic test_midrun_reset();
    mcu_write(16'h0017, 8'h03, 1'b1);
    @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    if (nmi !== 1'b0) begin $display("FAIL midreset_nmi got %b exp 0", nmi); errors++; end
    checks++;
    if (irqmain !== 1'b0) begin $display("FAIL midreset_irqmain got %b exp 0", irqmain); errors++; end
    checks++;
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    mcu_read(16'h0017);
    if (mcu_din !== 8'h00) begin $display("FAIL midreset_p6 got %h exp 00", mcu_din); errors++; end
    checks++;
    mcu_read(16'h0050);
    if (mcu_din !== 8'h77) begin $display("FAIL midreset_iram_keep got %h exp 77", mcu_din); errors++; end
    checks++;
    mcu_idle();
    $display("test_midrun_reset done");
  endtask

  initial begin
    test_reset();
    test_port();
    test_nmi();
    test_shared();
    test_iram_mux();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dd_mcu_mem_glue.md
Name: dd_mcu_mem_glue

Overview:
- Memory and glue subsystem around the 6801 sound/game MCU of the Double Dragon core. Sits between the MCU core, the main CPU bus and the external program ROM.
- Decodes MCU addresses and provides:
  - 512x8 dual-port shared RAM (MCU side and main-CPU side);
  - 256x8 internal MCU RAM;
  - 32-entry port register file, with port 6 driving the interrupt outputs;
  - edge-triggered NMI latch;
  - the MCU read-data multiplexer.

Parameters:
- SHW, 9, shared RAM address width (512 bytes)
- IRW, 8, internal RAM address width (256 bytes)

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rstb  in  1  asynchronous active-low reset
- cen  in  1  MCU clock enable
- vma  in  1  MCU valid memory address
- rnw  in  1  MCU read(1)/write(0)
- addr  in  16  MCU address bus
- mcu_dout  in  8  MCU write data
- mcu_din  out  8  MCU read data, combinational mux
- rom_data  in  8  program ROM data
- rom_cs  out  1  ROM select
- nmi_set  in  1  NMI request; rising edge sets the latch
- nmi  out  1  NMI to MCU
- irqmain  out  1  interrupt to main CPU
- halted  in  1  MCU halted acknowledge
- cpu_ab  in  9  main-CPU address into shared RAM
- cpu_wrn  in  1  main-CPU write strobe, active low
- cpu_dout  in  8  main-CPU write data
- com_cs  in  1  main-CPU shared-RAM select
- shared_dout  out  8  shared RAM data to main CPU

Behaviour:
- Decode is combinational; every select is 0 when vma=0.
  - rom_cs: addr[15:14]==2'b11.
  - ram_cs: 0x0040 <= addr < 0x0140. Internal RAM index is addr[7:0], so 0x100-0x13F alias 0x00-0x3F.
  - shared_cs: addr[15:12]==4'h8. Shared RAM index is addr[8:0].
  - port_cs: addr < 0x0028.
- mcu_din priority: ram_cs → internal RAM q; else shared_cs → shared q0; else port_cs → port read; else rom_data.
- Port write: port_cs & ~rnw & cen stores mcu_dout into port_file[addr[4:0]].
  - If addr[5:0]==6'h17, mcu_dout goes to p6 instead of the file.
  - Port read returns p6 for 6'h17, else port_file[addr[4:0]].
  - port_file is not reset. p6 resets to 0x00.
- irqmain = p6[1]. nmi_clr = ~p6[0].
- NMI latch:
  - nmi_set is registered every clk; a rising edge is (nmi_set & ~nmi_set_d).
  - Each clk: if nmi_clr, nmi←0; else if rising edge, nmi←1; else hold. Clear has priority over a simultaneous edge.
  - A level held high sets the latch only once.
  - Reset: nmi=0, nmi_set_d=0.
- Shared RAM, true dual port, one clk:
  - Port0 (MCU): addr[8:0], write when ~rnw & shared_cs (not gated by cen).
  - Port1 (CPU): cpu_ab, write when ~cpu_wrn & com_cs & halted. CPU writes are ignored while halted=0.
  - Reads are synchronous: q registered every clk, valid one clk after the address. Read-before-write: q shows the old data on a write cycle.
  - Same-address writes from both ports in one clk: port0 (MCU) data wins.
- Internal RAM:
  - Write when ram_cs & ~rnw & cen.
  - q registered every clk from addr[7:0], read-before-write, one clk latency.
- RAM contents are not reset and persist across reset.
- Reset (asynchronous assert, synchronous release): p6=0, so irqmain=0 and nmi_clr=1, which holds nmi at 0 until software writes p6[0]=1.

Test Plan:
- Reset: assert rstb=0 mid-run → nmi=0, irqmain=0 immediately; after release, reads of port 0x17 return 0x00.
- Port 6 write: vma=1, rnw=0, cen=1, addr=0x0017, data=0x03 → irqmain=1, NMI clear released; read 0x0017 returns 0x03. Write 0x05 to addr 0x0005 → read returns 0x05, p6 unchanged.
- NMI latch:
  - With p6[0]=1, pulse nmi_set 0→1 → nmi=1 next clk; hold nmi_set high → nmi stays 1 with no retrigger.
  - Write p6=0x00 → nmi=0.
  - nmi_set rising in the same clk as nmi_clr=1 → nmi stays 0.
- Shared RAM:
  - MCU writes 0xA5 at 0x8010 → CPU reads cpu_ab=0x010 and gets shared_dout=0xA5 one clk later.
  - CPU write 0x3C to 0x020 with halted=0 → ignored; with halted=1 → MCU read of 0x8020 returns 0x3C.
  - Simultaneous same-address writes → MCU value stored.
- Internal RAM and mux:
  - Write 0x77 at 0x0050 with cen=1 → read returns 0x77 after one clk.
  - Write with cen=0 → no change.
  - Read 0x0150 → not ram_cs, returns rom_data.
  - Read 0xC123 → rom_cs=1, mcu_din=rom_data.
  - vma=0 → all selects 0.
